// File: rtl/if_fetch_stage.sv
// if_fetch_stage: MIPS IF stage, owns the PC, drives instruction SRAM, keeps redirects that arrive while stalled (optional IF_INST_HOLD_EN adds a decode-stall instruction hold)
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int          STALL_W  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic [32:0]        br_bus,
`ifdef IF_INST_HOLD_EN
    input  logic [31:0]        inst_sram_rdata,
    output logic               inst_hold_v,
    output logic [31:0]        inst_hold,
`endif
    output logic [32:0]        if_to_id_bus,
    output logic               inst_sram_en,
    output logic [3:0]         inst_sram_wen,
    output logic [31:0]        inst_sram_addr,
    output logic [31:0]        inst_sram_wdata
);
    logic        br_e;
    logic [31:0] br_addr;
    logic [31:0] pc_reg;
    logic [31:0] next_pc;
    logic        ce_reg;
    logic        pend_v;
    logic [31:0] pend_addr;

    assign br_e            = br_bus[32];
    assign br_addr         = br_bus[31:0];
    assign inst_sram_en    = ce_reg;
    assign inst_sram_addr  = pc_reg;
    assign inst_sram_wen   = 4'b0;
    assign inst_sram_wdata = 32'b0;
    assign if_to_id_bus    = {ce_reg, pc_reg};

    // live redirect beats a held one, which beats sequential fetch
    always_comb begin
        next_pc = br_e ? br_addr : pend_v ? pend_addr : pc_reg + 32'd4;
    end

    // PC advances when IF is not stalled; redirects seen during a stall are parked, newest wins
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg    <= RESET_PC - 32'd4;
            ce_reg    <= 1'b0;
            pend_v    <= 1'b0;
            pend_addr <= 32'b0;
        end else if (!stall[0]) begin
            pc_reg <= next_pc;
            ce_reg <= 1'b1;
            pend_v <= 1'b0;
        end else if (br_e) begin
            pend_v    <= 1'b1;
            pend_addr <= br_addr;
        end
    end

`ifdef IF_INST_HOLD_EN
    logic id_stall_q;

    // latch SRAM data on the first decode-stall cycle so the word survives until decode resumes
    always_ff @(posedge clk) begin
        if (rst) begin
            id_stall_q  <= 1'b0;
            inst_hold_v <= 1'b0;
            inst_hold   <= 32'b0;
        end else begin
            id_stall_q <= stall[1];
            if (!stall[1]) begin
                inst_hold_v <= 1'b0;
            end else if (!id_stall_q) begin
                inst_hold_v <= 1'b1;
                inst_hold   <= inst_sram_rdata;
            end
        end
    end
`endif
endmodule
